// File: rtl/tcb_lib_misaligned_sram_ctrl_pipe_pkg.sv
// Shared types and helpers for the misaligned SRAM controller.
// - tcb_mcp_stage_t : one response delay-line stage {vld, wen, off, err}
// - tcb_rot         : modulo lane/bank index helper
package tcb_lib_misaligned_sram_ctrl_pipe_pkg;

    // Widest supported byte offset field (up to 256 banks).
    localparam int unsigned TCB_OFW_MAX = 8;
    // Response status width.
    localparam int unsigned TCB_STS_W = 1;

    typedef struct packed {
        logic                   vld;
        logic                   wen;
        logic [TCB_OFW_MAX-1:0] off;
        logic                   err;
    } tcb_mcp_stage_t;

    // Returns (idx - off) mod n. Passing n-off as the offset gives (idx + off) mod n.
    function automatic int unsigned tcb_rot(input int unsigned idx, input int unsigned off,
                                            input int unsigned n);
        return (idx + n - (off % n)) % n;
    endfunction

endpackage

// File: rtl/tcb_lib_misaligned_sram_ctrl_pipe_delay_line.sv
// Fixed-depth register pipeline of an arbitrary type, cleared by async reset.
// DEPTH=0 degenerates to a wire.
// Ports:
// - clk   : clock, rising edge
// - rst_n : asynchronous reset, active low (all stages clear to '0)
// - din   : pipeline input
// - dout  : value of din delayed by DEPTH cycles
module tcb_lib_misaligned_sram_ctrl_pipe_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  T     din,
    output T     dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign dout = din;
    end else begin : g_pipe
        T stage_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/tcb_lib_misaligned_sram_ctrl_pipe.sv
// TCB subordinate mapping byte-enable accesses (optionally misaligned) onto BEN byte-wide
// SRAM banks. Write data/enables are rotated into bank order by the address offset, banks
// that wrap past the last lane address the next row, and read data is rotated back.
// A response delay line aligns SRAM latency MEM_DLY with the bus response delay DLY.
// Ports:
// - clk, rst_n          : clock, async active-low reset
// - tcb_vld/wen/adr/ben/wdt : bus request; tcb_rdy is constantly 1
// - tcb_rdt, tcb_sts    : bus response, DLY cycles after the request
// - mem_cen             : per-bank chip enable
// - mem_wen             : shared write enable
// - mem_adr             : per-bank row address
// - mem_wdt             : per-bank write byte
// - mem_rdt             : per-bank read byte, valid MEM_DLY cycles after cen
module tcb_lib_misaligned_sram_ctrl_pipe
    import tcb_lib_misaligned_sram_ctrl_pipe_pkg::*;
#(
    parameter int unsigned DAT     = 32,
    parameter int unsigned ADR     = 32,
    parameter int unsigned DLY     = 1,
    parameter int unsigned MEM_DLY = 1,
    parameter bit          MIS     = 1'b1,
    localparam int unsigned BEN    = DAT / 8,
    localparam int unsigned OFW    = $clog2(BEN),
    localparam int unsigned RAW    = ADR - OFW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tcb_vld,
    input  logic                      tcb_wen,
    input  logic [ADR-1:0]            tcb_adr,
    input  logic [BEN-1:0]            tcb_ben,
    input  logic [DAT-1:0]            tcb_wdt,
    output logic                      tcb_rdy,
    output logic [DAT-1:0]            tcb_rdt,
    output logic [TCB_STS_W-1:0]      tcb_sts,
    output logic [BEN-1:0]            mem_cen,
    output logic                      mem_wen,
    output logic [BEN-1:0][RAW-1:0]   mem_adr,
    output logic [BEN-1:0][7:0]       mem_wdt,
    input  logic [BEN-1:0][7:0]       mem_rdt
);

    // Offset field is at least one bit wide so single-bank builds still elaborate.
    localparam int unsigned OFP = (OFW > 0) ? OFW : 1;

    if ((MEM_DLY < 1) || (MEM_DLY > DLY)) begin : g_chk_dly
        $error("MEM_DLY must satisfy 1 <= MEM_DLY <= DLY");
    end
    if ((DAT < 8) || ((DAT & (DAT - 1)) != 0)) begin : g_chk_dat
        $error("DAT must be a power of two >= 8");
    end
    if (OFW > TCB_OFW_MAX) begin : g_chk_ofw
        $error("DAT too wide for the stage offset field");
    end

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    logic [OFP-1:0]     off;
    logic [RAW-1:0]     row;
    logic [RAW-1:0]     nxt;
    logic               err;
    logic [BEN-1:0][7:0] wdt_b;

    if (OFW > 0) begin : g_off
        assign off = tcb_adr[OFW-1:0];
    end else begin : g_no_off
        assign off = '0;
    end

    assign row   = tcb_adr[ADR-1:OFW];
    assign nxt   = row + RAW'(1);  // top row wraps to row 0
    assign err   = ~MIS & (off != '0) & tcb_vld;
    assign wdt_b = tcb_wdt;

    assign tcb_rdy = 1'b1;
    assign mem_wen = tcb_wen;

    always_comb begin
        logic [OFP-1:0] lane;
        mem_cen = '0;
        mem_adr = '0;
        mem_wdt = '0;
        lane    = '0;
        for (int unsigned b = 0; b < BEN; b++) begin
            lane       = OFP'(tcb_rot(b, int'(off), BEN));
            mem_cen[b] = tcb_vld & tcb_ben[lane] & ~err;
            mem_wdt[b] = wdt_b[lane];
            // Banks below the offset hold lanes that spilled into the next row.
            mem_adr[b] = (b < int'(off)) ? nxt : row;
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    tcb_mcp_stage_t req_stage;
    tcb_mcp_stage_t mem_stage;  // stage aligned with valid mem_rdt
    tcb_mcp_stage_t rsp_stage;  // stage aligned with the bus response

    always_comb begin
        req_stage     = '0;
        req_stage.vld = tcb_vld;
        req_stage.wen = tcb_wen;
        req_stage.off = TCB_OFW_MAX'(off);
        req_stage.err = err;
    end

    tcb_lib_misaligned_sram_ctrl_pipe_delay_line #(
        .DEPTH (MEM_DLY),
        .T     (tcb_mcp_stage_t)
    ) u_mem_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (req_stage),
        .dout  (mem_stage)
    );

    tcb_lib_misaligned_sram_ctrl_pipe_delay_line #(
        .DEPTH (DLY - MEM_DLY),
        .T     (tcb_mcp_stage_t)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mem_stage),
        .dout  (rsp_stage)
    );

    // Rotate bank data back into bus lane order; non-read stages return zero.
    logic [BEN-1:0][7:0] rdt_rot;
    logic [DAT-1:0]      rdt_rot_flat;

    always_comb begin
        logic [OFP-1:0] bank;
        rdt_rot = '0;
        bank    = '0;
        if (mem_stage.vld && !mem_stage.wen) begin
            for (int unsigned l = 0; l < BEN; l++) begin
                bank       = OFP'(tcb_rot(l, BEN - int'(mem_stage.off[OFP-1:0]), BEN));
                rdt_rot[l] = mem_rdt[bank];
            end
        end
    end

    assign rdt_rot_flat = rdt_rot;

    tcb_lib_misaligned_sram_ctrl_pipe_delay_line #(
        .DEPTH (DLY - MEM_DLY),
        .T     (logic [DAT-1:0])
    ) u_dat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rdt_rot_flat),
        .dout  (tcb_rdt)
    );

    assign tcb_sts = TCB_STS_W'(rsp_stage.vld & rsp_stage.err);

    logic unused_stage;
    assign unused_stage = ^{rsp_stage.wen, rsp_stage.off, mem_stage.off, mem_stage.err};

endmodule

// File: tb/tb_tcb_lib_misaligned_sram_ctrl_pipe.sv
// Directed bench: two controller instances (MIS=1, MIS=0) share request fields, each with
// its own byte-addressed SRAM model preloaded with byte = byte address.
module tb_tcb_lib_misaligned_sram_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vld1, vld0, wen;
    logic [31:0] adr, wdt;
    logic [3:0]  ben;

    logic             rdy1, rdy0;
    logic [31:0]      rdt1, rdt0;
    logic [0:0]       sts1, sts0;
    logic [3:0]       cen1, cen0;
    logic             mwen1, mwen0;
    logic [3:0][29:0] madr1, madr0;
    logic [3:0][7:0]  mwdt1, mwdt0;
    logic [3:0][7:0]  mrdt1, mrdt0;

    logic [7:0] mem1 [logic [31:0]];
    logic [7:0] mem0 [logic [31:0]];

    int n_total = 0;
    int n_bad   = 0;

    tcb_lib_misaligned_sram_ctrl_pipe #(
        .DAT (32), .ADR (32), .DLY (2), .MEM_DLY (1), .MIS (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tcb_vld (vld1),
        .tcb_wen (wen),
        .tcb_adr (adr),
        .tcb_ben (ben),
        .tcb_wdt (wdt),
        .tcb_rdy (rdy1),
        .tcb_rdt (rdt1),
        .tcb_sts (sts1),
        .mem_cen (cen1),
        .mem_wen (mwen1),
        .mem_adr (madr1),
        .mem_wdt (mwdt1),
        .mem_rdt (mrdt1)
    );

    tcb_lib_misaligned_sram_ctrl_pipe #(
        .DAT (32), .ADR (32), .DLY (2), .MEM_DLY (1), .MIS (1'b0)
    ) dut_nomis (
        .clk     (clk),
        .rst_n   (rst_n),
        .tcb_vld (vld0),
        .tcb_wen (wen),
        .tcb_adr (adr),
        .tcb_ben (ben),
        .tcb_wdt (wdt),
        .tcb_rdy (rdy0),
        .tcb_rdt (rdt0),
        .tcb_sts (sts0),
        .mem_cen (cen0),
        .mem_wen (mwen0),
        .mem_adr (madr0),
        .mem_wdt (mwdt0),
        .mem_rdt (mrdt0)
    );

    // SRAM models: one-cycle registered read, byte address = {row, bank}.
    always @(posedge clk) begin
        logic [31:0] k;
        for (int b = 0; b < 4; b++) begin
            if (cen1[b]) begin
                k = {madr1[b], 2'(b)};
                if (mwen1) mem1[k] = mwdt1[b];
                else       mrdt1[b] <= mem1.exists(k) ? mem1[k] : k[7:0];
            end
        end
    end

    always @(posedge clk) begin
        logic [31:0] k;
        for (int b = 0; b < 4; b++) begin
            if (cen0[b]) begin
                k = {madr0[b], 2'(b)};
                if (mwen0) mem0[k] = mwdt0[b];
                else       mrdt0[b] <= mem0.exists(k) ? mem0[k] : k[7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic v0, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        vld1 = v1;
        vld0 = v0;
        wen  = w;
        adr  = a;
        ben  = b;
        wdt  = d;
    endtask

    task automatic idle();
        vld1 = 1'b0;
        vld0 = 1'b0;
        wen  = 1'b0;
    endtask

    // Preloaded word at an aligned address whose low byte does not carry.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [7:0] x;
        x = a[7:0];
        return {x + 8'd3, x + 8'd2, x + 8'd1, x};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        mrdt1 = '0;
        mrdt0 = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("rst_rdt", 128'(rdt1), 128'h0);
        check("rst_sts", 128'(sts1), 128'h0);
        check("rst_rdy", 128'(rdy1), 128'h1);
        check("rst_cen", 128'(cen1), 128'h0);

        // Aligned read
        cyc(); drive(1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0); #1;
        check("al_cen", 128'(cen1), 128'hF);
        check("al_adr", 128'(madr1), 128'({30'd4, 30'd4, 30'd4, 30'd4}));
        check("al_wen", 128'(mwen1), 128'h0);
        cyc(); idle(); #1;
        cyc(); #1;
        check("al_rdt", 128'(rdt1), 128'h13121110);
        check("al_sts", 128'(sts1), 128'h0);

        // Misaligned write followed immediately by read-back
        cyc(); drive(1'b1, 1'b0, 1'b1, 32'h13, 4'hF, 32'hDDCCBBAA); #1;
        check("mw_cen", 128'(cen1), 128'hF);
        check("mw_wen", 128'(mwen1), 128'h1);
        check("mw_wdt", 128'(mwdt1), 128'hAADDCCBB);
        check("mw_adr", 128'(madr1), 128'({30'd4, 30'd5, 30'd5, 30'd5}));
        cyc(); drive(1'b1, 1'b0, 1'b0, 32'h13, 4'hF, 32'h0); #1;
        check("mw_b3r4", 128'(mem1[32'h13]), 128'hAA);
        check("mw_b0r5", 128'(mem1[32'h14]), 128'hBB);
        check("mw_b1r5", 128'(mem1[32'h15]), 128'hCC);
        check("mw_b2r5", 128'(mem1[32'h16]), 128'hDD);
        cyc(); idle(); #1;
        check("mw_rsp_rdt", 128'(rdt1), 128'h0);
        check("mw_rsp_sts", 128'(sts1), 128'h0);
        cyc(); #1;
        check("mr_rdt", 128'(rdt1), 128'hDDCCBBAA);
        check("mr_sts", 128'(sts1), 128'h0);

        // Partial misaligned read
        cyc(); drive(1'b1, 1'b0, 1'b0, 32'h0A, 4'b0011, 32'h0); #1;
        check("pr_cen", 128'(cen1), 128'hC);
        check("pr_adr3", 128'(madr1[3]), 128'd2);
        check("pr_adr2", 128'(madr1[2]), 128'd2);
        cyc(); idle(); #1;
        cyc(); #1;
        check("pr_rdt", 128'(rdt1[15:0]), 128'h0B0A);

        // Top-row wrap
        cyc(); drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'hF, 32'h0); #1;
        check("wr_cen", 128'(cen1), 128'hF);
        check("wr_adr", 128'(madr1), 128'({30'h3FFF_FFFF, 30'h3FFF_FFFF, 30'd0, 30'd0}));
        cyc(); idle(); #1;
        cyc(); #1;
        check("wr_rdt", 128'(rdt1), 128'h0100FFFE);

        // Misalignment rejected when MIS=0
        cyc(); drive(1'b0, 1'b1, 1'b1, 32'h21, 4'hF, 32'h11223344); #1;
        check("er_cen", 128'(cen0), 128'h0);
        cyc(); idle(); #1;
        check("er_sts_early", 128'(sts0), 128'h0);
        cyc(); #1;
        check("er_sts", 128'(sts0), 128'h1);
        check("er_rdt", 128'(rdt0), 128'h0);
        check("er_nowr", 128'(mem0.num()), 128'h0);
        cyc(); drive(1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0); #1;
        check("ok_cen", 128'(cen0), 128'hF);
        cyc(); idle(); #1;
        check("ok_sts_clr", 128'(sts0), 128'h0);
        cyc(); #1;
        check("ok_sts", 128'(sts0), 128'h0);
        check("ok_rdt", 128'(rdt0), 128'h23222120);

        // Back-to-back reads with a reset pulse in cycle 8
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 8) begin
                rst_n = 1'b0;
                idle();
            end else begin
                rst_n = 1'b1;
                drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'h0);
            end
            #1;
            if (i >= 2) begin
                check($sformatf("b2b_%0d", i), 128'(rdt1),
                      (i >= 8 && i <= 10) ? 128'h0
                                          : 128'(exp_word(32'h100 + 32'(4 * (i - 2)))));
            end
        end
        for (int j = 16; j < 18; j++) begin
            cyc(); idle(); #1;
            check($sformatf("b2b_%0d", j), 128'(rdt1),
                  128'(exp_word(32'h100 + 32'(4 * (j - 2)))));
        end
        cyc(); #1;
        check("b2b_tail", 128'(rdt1), 128'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
